// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI secondary: FSM state encoding, default
// parameter values and the fill pattern shifted out when no tx word is ready.
// -----------------------------------------------------------------------------
package spi_pkg;

   // Secondary FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } spi_state_e;

   localparam int DWIDTH_DEF      = 8;
   localparam int SYNC_STAGES_DEF = 2;

   // Pattern shifted out on underrun; sliced to DWIDTH by the user (DWIDTH <= 64)
   localparam logic [63:0] IDLE_FILL = {64{1'b1}};

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous input, followed by one extra
// flop so that rising/falling transitions of the synchronized level are
// reported as single-cycle strobes.
//
// The chain resets to 0, so an input that is already low when reset is
// released never produces a fall strobe: it must first be seen high.
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   asynchronous input
//   rise out  one-cycle strobe, synchronized level went 0 -> 1
//   fall out  one-cycle strobe, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   level_s;

   assign level_s = sync_r[SYNC_STAGES-1];

   // Synchronizer chain plus the edge-compare flop
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev_r <= level_s;
      end
   end

   assign rise = level_s & ~prev_r;
   assign fall = ~level_s & prev_r;

endmodule : spi_sync_edge

// File: rtl/spi_secondary.sv
// -----------------------------------------------------------------------------
// spi_secondary
// System-clocked SPI mode-0 secondary. sclk, cs_n and mosi are oversampled on
// clk; mosi is captured on sclk rising edges, miso advances on falling edges,
// MSB first. A one-word tx holding register feeds the shifter; completed rx
// words are presented on rx_data with an rx_valid indication.
//
// Optional build macro SPI_SECONDARY_RX_ACK_EN:
//   adds rx_ready (in) and overrun (out, sticky); rx_valid then holds until
//   accepted, and a word completing while rx_valid is high sets overrun.
//   Without it, rx_valid is a one-cycle pulse per completed word.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, cs_n, mosi  asynchronous SPI bus inputs
//   miso              registered serial output
//   tx_data/valid/ready  tx holding register load handshake
//   rx_data, rx_valid last received word and its valid indication
//   busy              synchronized cs_n is low
//   underrun          one-cycle pulse: word started with empty holding reg
//   rx_ready, overrun (SPI_SECONDARY_RX_ACK_EN only)
// -----------------------------------------------------------------------------
module spi_secondary
   import spi_pkg::*;
#(
   parameter int DWIDTH      = DWIDTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
`ifdef SPI_SECONDARY_RX_ACK_EN
   input  logic              rx_ready,
   output logic              overrun,
`endif
   output logic              underrun
);

   localparam int                CNT_W    = $clog2(DWIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DWIDTH - 1);
   localparam logic [DWIDTH-1:0] FILL     = IDLE_FILL[DWIDTH-1:0];

   // Synchronized bus events
   logic                   sclk_rise_s, sclk_fall_s;
   logic                   cs_rise_s, cs_fall_s;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   mosi_s;

   // State and datapath registers with their next values
   spi_state_e        state_r, state_n;
   logic [DWIDTH-1:0] tx_sr_r, tx_sr_n;
   logic [DWIDTH-1:0] rx_sr_r, rx_sr_n;
   logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_n;
   logic [DWIDTH-1:0] hold_r, hold_n;
   logic              tx_ready_r, tx_ready_n;
   logic              miso_r, miso_n;
   logic [DWIDTH-1:0] rx_data_r, rx_data_n;
   logic              rx_valid_r, rx_valid_n;
   logic              busy_r, busy_n;
   logic              underrun_r, underrun_n;
`ifdef SPI_SECONDARY_RX_ACK_EN
   logic              overrun_r, overrun_n;
`endif

   logic [DWIDTH-1:0] rx_shift_s;
   logic              word_done_s;
   // MSBs of the shifters are shifted out / overwritten and never read back
   logic              unused_msb_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (sclk),
      .rise (sclk_rise_s),
      .fall (sclk_fall_s)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (cs_n),
      .rise (cs_rise_s),
      .fall (cs_fall_s)
   );

   // mosi only needs a synchronized level, sampled on sclk rise strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      end
   end

   assign mosi_s       = mosi_sync_r[SYNC_STAGES-1];
   assign rx_shift_s   = {rx_sr_r[DWIDTH-2:0], mosi_s};
   assign unused_msb_s = rx_sr_r[DWIDTH-1] ^ tx_sr_r[DWIDTH-1];

   // Next-state and datapath logic for the transfer FSM
   always_comb begin
      state_n     = state_r;
      tx_sr_n     = tx_sr_r;
      rx_sr_n     = rx_sr_r;
      bit_cnt_n   = bit_cnt_r;
      hold_n      = hold_r;
      tx_ready_n  = tx_ready_r;
      miso_n      = miso_r;
      rx_data_n   = rx_data_r;
      underrun_n  = 1'b0;
      word_done_s = 1'b0;

      // Local load of the holding register; never coincides with a LOAD
      // consume because that requires tx_ready_r == 0
      if (tx_valid && tx_ready_r) begin
         hold_n     = tx_data;
         tx_ready_n = 1'b0;
      end else begin
         hold_n     = hold_r;
      end

      case (state_r)
         IDLE: begin
            if (cs_fall_s) begin
               state_n = LOAD;
            end else begin
               state_n = IDLE;
            end
         end
         LOAD: begin
            if (cs_rise_s) begin
               state_n = IDLE;
            end else if (!tx_ready_r) begin
               tx_sr_n    = hold_r;
               tx_ready_n = 1'b1;
               miso_n     = hold_r[DWIDTH-1];
               state_n    = SHIFT;
            end else begin
               tx_sr_n    = FILL;
               underrun_n = 1'b1;
               miso_n     = FILL[DWIDTH-1];
               state_n    = SHIFT;
            end
         end
         SHIFT: begin
            if (sclk_rise_s) begin
               if (bit_cnt_r == LAST_BIT) begin
                  // Delivered even if cs_n rises in this same cycle
                  word_done_s = 1'b1;
                  rx_data_n   = rx_shift_s;
                  rx_sr_n     = {DWIDTH{1'b0}};
                  bit_cnt_n   = {CNT_W{1'b0}};
               end else begin
                  rx_sr_n     = rx_shift_s;
                  bit_cnt_n   = bit_cnt_r + CNT_W'(1);
               end
            end else if (sclk_fall_s) begin
               if (bit_cnt_r != {CNT_W{1'b0}}) begin
                  tx_sr_n = {tx_sr_r[DWIDTH-2:0], 1'b0};
                  miso_n  = tx_sr_r[DWIDTH-2];
               end else begin
                  // Word boundary with cs_n still low: fetch the next word
                  state_n = LOAD;
               end
            end else begin
               state_n = SHIFT;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Deselect wins over any sclk activity in the same cycle
      if (cs_rise_s) begin
         state_n   = IDLE;
         bit_cnt_n = {CNT_W{1'b0}};
         rx_sr_n   = {DWIDTH{1'b0}};
         miso_n    = 1'b0;
      end else begin
         state_n   = state_n;
      end

      if (cs_fall_s) begin
         busy_n = 1'b1;
      end else if (cs_rise_s) begin
         busy_n = 1'b0;
      end else begin
         busy_n = busy_r;
      end

`ifdef SPI_SECONDARY_RX_ACK_EN
      overrun_n = overrun_r;
      if (word_done_s) begin
         rx_valid_n = 1'b1;
         if (rx_valid_r && !rx_ready) begin
            overrun_n = 1'b1;
         end else begin
            overrun_n = overrun_r;
         end
      end else if (rx_valid_r && rx_ready) begin
         rx_valid_n = 1'b0;
      end else begin
         rx_valid_n = rx_valid_r;
      end
`else
      rx_valid_n = word_done_s;
`endif
   end

   // State and datapath register bank
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         tx_sr_r    <= {DWIDTH{1'b0}};
         rx_sr_r    <= {DWIDTH{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         hold_r     <= {DWIDTH{1'b0}};
         tx_ready_r <= 1'b1;
         miso_r     <= 1'b0;
         rx_data_r  <= {DWIDTH{1'b0}};
         rx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         underrun_r <= 1'b0;
`ifdef SPI_SECONDARY_RX_ACK_EN
         overrun_r  <= 1'b0;
`endif
      end else begin
         state_r    <= state_n;
         tx_sr_r    <= tx_sr_n;
         rx_sr_r    <= rx_sr_n;
         bit_cnt_r  <= bit_cnt_n;
         hold_r     <= hold_n;
         tx_ready_r <= tx_ready_n;
         miso_r     <= miso_n;
         rx_data_r  <= rx_data_n;
         rx_valid_r <= rx_valid_n;
         busy_r     <= busy_n;
         underrun_r <= underrun_n;
`ifdef SPI_SECONDARY_RX_ACK_EN
         overrun_r  <= overrun_n;
`endif
      end
   end

   assign miso     = miso_r;
   assign tx_ready = tx_ready_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign busy     = busy_r;
   assign underrun = underrun_r;
`ifdef SPI_SECONDARY_RX_ACK_EN
   assign overrun  = overrun_r;
`endif

endmodule : spi_secondary

// File: tb/tb_spi_secondary.sv
// -----------------------------------------------------------------------------
// tb_spi_secondary
// Drives the SPI bus as a mode-0 primary (4 clk per sclk phase) and checks
// miso bits and received words against scoreboard queues filled as the
// stimulus is driven.
// -----------------------------------------------------------------------------
module tb_spi_secondary;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       underrun;
`ifdef SPI_SECONDARY_RX_ACK_EN
   logic       rx_ready;
   logic       overrun;
`endif

   int chk_cnt = 0;
   int err_cnt = 0;
   int underrun_cnt = 0;

   logic [7:0] rx_q[$];
   logic       miso_q[$];

   spi_secondary #(.DWIDTH(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .cs_n     (cs_n),
      .mosi     (mosi),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
`ifdef SPI_SECONDARY_RX_ACK_EN
      .rx_ready (rx_ready),
      .overrun  (overrun),
`endif
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_tx(input logic [7:0] d);
      int guard = 0;
      while (tx_ready !== 1'b1 && guard < 200) begin
         wait_clk(1);
         guard++;
      end
      if (guard >= 200) check_eq("tx_ready_timeout", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      wait_clk(8);
   endtask

   task automatic cs_high();
      wait_clk(6);
      cs_n = 1'b1;
      wait_clk(8);
   endtask

   // Shift nbits MSB-first; expected miso bits queued as each bit is driven
   task automatic xfer_bits(input logic [7:0] mosi_w, input logic [7:0] miso_w,
                            input int nbits, input bit push_rx);
      if (push_rx) rx_q.push_back(mosi_w);
      for (int i = 0; i < nbits; i++) begin
         mosi = mosi_w[7-i];
         miso_q.push_back(miso_w[7-i]);
         wait_clk(4);
         check_eq("miso", miso, miso_q.pop_front());
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   // Output monitor: received words against the rx scoreboard, underrun count
   always @(negedge clk) begin
      if (!rst) begin
         if (underrun) underrun_cnt++;
`ifdef SPI_SECONDARY_RX_ACK_EN
         if (rx_valid && rx_ready) begin
`else
         if (rx_valid) begin
`endif
            if (rx_q.size() == 0) check_eq("rx_spurious", rx_q.size(), 1);
            else check_eq("rx_data", rx_data, rx_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0;
`ifdef SPI_SECONDARY_RX_ACK_EN
      rx_ready = 1'b1;
`endif
      wait_clk(4);
      check_eq("rst_miso", miso, 0);
      check_eq("rst_tx_ready", tx_ready, 1);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_underrun", underrun, 0);
      rst = 1'b0;
      wait_clk(10);
      check_eq("idle_busy", busy, 0);

      // 1: single word, preloaded holding register
      load_tx(8'hA5);
      check_eq("t1_tx_ready_full", tx_ready, 0);
      underrun_cnt = 0;
      cs_low();
      check_eq("t1_underrun", underrun_cnt, 0);
      check_eq("t1_tx_ready_after_load", tx_ready, 1);
      check_eq("t1_busy", busy, 1);
      xfer_bits(8'h3C, 8'hA5, 8, 1'b1);
      cs_high();
      check_eq("t1_rx_pending", rx_q.size(), 0);
      check_eq("t1_rx_hold", rx_data, 8'h3C);
      check_eq("t1_busy_end", busy, 0);
      check_eq("t1_miso_end", miso, 0);

      // 2: back-to-back words in one frame
      load_tx(8'h12);
      cs_low();
      load_tx(8'h34);
      xfer_bits(8'hF0, 8'h12, 8, 1'b1);
      xfer_bits(8'h0F, 8'h34, 8, 1'b1);
      cs_high();
      check_eq("t2_rx_pending", rx_q.size(), 0);

      // 3: empty holding register at frame start
      underrun_cnt = 0;
      cs_low();
      check_eq("t3_underrun", underrun_cnt, 1);
      xfer_bits(8'h6B, 8'hFF, 8, 1'b1);
      cs_high();
      check_eq("t3_rx_pending", rx_q.size(), 0);

      // 4: deselect after 5 bits, then a normal frame
      load_tx(8'h99);
      cs_low();
      xfer_bits(8'hC3, 8'h99, 5, 1'b0);
      cs_high();
      check_eq("t4_bit_cnt", dut.bit_cnt_r, 0);
      check_eq("t4_miso", miso, 0);
      check_eq("t4_rx_keep", rx_data, 8'h6B);
      load_tx(8'h5A);
      cs_low();
      xfer_bits(8'h96, 8'h5A, 8, 1'b1);
      cs_high();
      check_eq("t4_rx_pending", rx_q.size(), 0);

      // 5: reset in the middle of a word
      load_tx(8'h77);
      cs_low();
      xfer_bits(8'hE0, 8'h77, 3, 1'b0);
      rst = 1'b1;
      wait_clk(2);
      check_eq("t5_miso", miso, 0);
      check_eq("t5_tx_ready", tx_ready, 1);
      check_eq("t5_rx_data", rx_data, 0);
      check_eq("t5_rx_valid", rx_valid, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_underrun", underrun, 0);
      rst = 1'b0;
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(10);
      load_tx(8'h3C);
      cs_low();
      xfer_bits(8'h81, 8'h3C, 8, 1'b1);
      cs_high();
      check_eq("t5_rx_pending", rx_q.size(), 0);
      check_eq("t5_rx_data_after", rx_data, 8'h81);

`ifdef SPI_SECONDARY_RX_ACK_EN
      // 6: words not accepted -> overwrite and overrun
      rx_ready = 1'b0;
      load_tx(8'h21);
      cs_low();
      xfer_bits(8'h11, 8'h21, 8, 1'b0);
      xfer_bits(8'h22, 8'hFF, 8, 1'b0);
      cs_high();
      check_eq("t6_rx_data", rx_data, 8'h22);
      check_eq("t6_overrun", overrun, 1);
      check_eq("t6_rx_valid_held", rx_valid, 1);
      wait_clk(3);
      check_eq("t6_rx_valid_still", rx_valid, 1);
      rx_q.push_back(8'h22);
      rx_ready = 1'b1;
      wait_clk(1);
      wait_clk(1);
      check_eq("t6_rx_valid_clr", rx_valid, 0);
      check_eq("t6_overrun_sticky", overrun, 1);
      check_eq("t6_rx_pending", rx_q.size(), 0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_spi_secondary
